// File: rtl/noc_stream_arbiter.sv
// Packet-level round-robin arbiter: N_PORTS AXI-stream requesters share one NoC ingress stream.
// One arbitration bubble per packet; the grant is held until the TLAST beat handshakes, so packets never interleave.
module noc_stream_arbiter #(
  parameter  int N_PORTS = 4,
  localparam int ID_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_low,
  input  logic [N_PORTS-1:0]      port_en,
  input  logic [N_PORTS-1:0]      in_TVALID,
  input  logic [N_PORTS*32-1:0]   in_TDATA,
  input  logic [N_PORTS*4-1:0]    in_TKEEP,
  input  logic [N_PORTS-1:0]      in_TLAST,
  output logic [N_PORTS-1:0]      in_TREADY,
  output logic                    out_TVALID,
  output logic [31:0]             out_TDATA,
  output logic [3:0]              out_TKEEP,
  output logic                    out_TLAST,
  input  logic                    out_TREADY,
  output logic                    grant_valid,
  output logic [ID_W-1:0]         grant_id,
  output logic                    pkt_done
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            pkt_done_q, pkt_done_d;

  logic [N_PORTS-1:0] req;
  logic [ID_W-1:0]    pick;
  logic               pick_vld;
  logic               busy;
  logic               last_beat;

  assign req  = in_TVALID & port_en;
  assign busy = (state_q == BUSY);

  // First requester at or after rr_ptr, wrapping modulo N_PORTS.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!pick_vld && req[ID_W'(idx)]) begin
        pick     = ID_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    out_TVALID = 1'b0;
    out_TDATA  = '0;
    out_TKEEP  = '0;
    out_TLAST  = 1'b0;
    in_TREADY  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (busy && (grant_id_q == ID_W'(i))) begin
        out_TVALID   = in_TVALID[i];
        out_TDATA    = in_TDATA[32*i +: 32];
        out_TKEEP    = in_TKEEP[4*i +: 4];
        out_TLAST    = in_TLAST[i];
        in_TREADY[i] = out_TREADY;
      end
    end
  end

  assign last_beat = busy & out_TVALID & out_TREADY & out_TLAST;

  // rr_ptr moves only on packet completion, so a grant alone never costs a port its turn.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    pkt_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = BUSY;
          grant_id_d = pick;
        end
      end
      BUSY: begin
        if (last_beat) begin
          state_d    = IDLE;
          pkt_done_d = 1'b1;
          rr_ptr_d   = (grant_id_q == ID_W'(N_PORTS-1)) ? '0 : grant_id_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_low) begin
    if (!rst_low) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign grant_valid = busy;
  assign grant_id    = grant_id_q;
  assign pkt_done    = pkt_done_q;

endmodule

// File: tb/tb_noc_stream_arbiter.sv
// Bench for noc_stream_arbiter: per-port packet sources feed the DUT, a scoreboard holds
// the beats in the bench's predicted grant order and is checked as beats leave out_*.
module tb_noc_stream_arbiter;

  localparam int NP = 4;

  typedef struct {
    int          port;
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_low = 1'b0;
  logic [NP-1:0]   port_en = '1;
  logic [NP-1:0]   in_TVALID = '0;
  logic [NP*32-1:0] in_TDATA = '0;
  logic [NP*4-1:0] in_TKEEP = '0;
  logic [NP-1:0]   in_TLAST = '0;
  logic [NP-1:0]   in_TREADY;
  logic            out_TVALID;
  logic [31:0]     out_TDATA;
  logic [3:0]      out_TKEEP;
  logic            out_TLAST;
  logic            out_TREADY = 1'b1;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic            pkt_done;

  noc_stream_arbiter #(.N_PORTS(NP)) dut (
    .clk(clk), .rst_low(rst_low), .port_en(port_en),
    .in_TVALID(in_TVALID), .in_TDATA(in_TDATA), .in_TKEEP(in_TKEEP),
    .in_TLAST(in_TLAST), .in_TREADY(in_TREADY),
    .out_TVALID(out_TVALID), .out_TDATA(out_TDATA), .out_TKEEP(out_TKEEP),
    .out_TLAST(out_TLAST), .out_TREADY(out_TREADY),
    .grant_valid(grant_valid), .grant_id(grant_id), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  int      n_vec  = 0;
  int      n_fail = 0;
  int      cyc    = 0;
  beat_t   src_q [NP][$];
  beat_t   exp_q [$];
  int      hs_edges [$];
  bit      hs_flag [NP];
  bit      prev_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_src(input int p, input int n, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.port = p; b.d = base + 32'(i); b.k = (i == n-1) ? 4'h3 : 4'hF; b.l = (i == n-1);
      src_q[p].push_back(b);
    end
  endtask

  task automatic push_exp(input int p, input int n, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.port = p; b.d = base + 32'(i); b.k = (i == n-1) ? 4'h3 : 4'hF; b.l = (i == n-1);
      exp_q.push_back(b);
    end
  endtask

  task automatic flush_all();
    for (int p = 0; p < NP; p++) src_q[p].delete();
    exp_q.delete();
    hs_edges.delete();
  endtask

  task automatic do_reset();
    rst_low = 1'b0; out_TREADY = 1'b1; port_en = '1;
    flush_all();
    repeat (2) @(posedge clk);
    #2 rst_low = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  // Sources: pop a beat that handshook on the previous edge, then present the next one.
  initial begin : driver
    forever begin
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
        if (hs_flag[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (src_q[p].size() > 0) begin
          in_TVALID[p] = 1'b1;
          in_TDATA[32*p +: 32] = src_q[p][0].d;
          in_TKEEP[4*p +: 4]   = src_q[p][0].k;
          in_TLAST[p]          = src_q[p][0].l;
        end else begin
          in_TVALID[p] = 1'b0;
          in_TDATA[32*p +: 32] = '0;
          in_TKEEP[4*p +: 4]   = '0;
          in_TLAST[p]          = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    beat_t e;
    int    ep;
    logic [NP-1:0] rdy_exp;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) hs_flag[p] = rst_low & in_TVALID[p] & in_TREADY[p];
      if (!rst_low) begin
        prev_last = 1'b0;
      end else begin
        n_vec++;
        if (pkt_done !== prev_last) begin
          n_fail++; $display("FAIL pkt_done got=%0b exp=%0b cyc=%0d", pkt_done, prev_last, cyc);
        end
        prev_last = 1'b0;
        if (grant_valid) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL unexpected_grant grant_id=%0d exp=no grant cyc=%0d", grant_id, cyc);
          end else begin
            ep = exp_q[0].port;
            if (grant_id !== 2'(ep)) begin
              n_fail++; $display("FAIL grant_id got=%0d exp=%0d cyc=%0d", grant_id, ep, cyc);
            end
            rdy_exp = '0;
            rdy_exp[ep] = out_TREADY;
            n_vec++;
            if (in_TREADY !== rdy_exp) begin
              n_fail++; $display("FAIL in_tready got=%b exp=%b cyc=%0d", in_TREADY, rdy_exp, cyc);
            end
            if (out_TVALID && out_TREADY) begin
              e = exp_q.pop_front();
              n_vec++;
              if ({out_TDATA, out_TKEEP, out_TLAST} !== {e.d, e.k, e.l}) begin
                n_fail++;
                $display("FAIL beat got=%h/%h/%b exp=%h/%h/%b cyc=%0d",
                         out_TDATA, out_TKEEP, out_TLAST, e.d, e.k, e.l, cyc);
              end
              hs_edges.push_back(cyc + 1);
              prev_last = out_TLAST;
            end
          end
        end else begin
          n_vec++;
          if (out_TVALID !== 1'b0 || in_TREADY !== '0) begin
            n_fail++; $display("FAIL idle_outputs got=%b/%b exp=0/0000 cyc=%0d", out_TVALID, in_TREADY, cyc);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_low = 1'b0;
    flush_all();
    push_src(1, 2, 32'h50);
    repeat (2) @(posedge clk); #2;
    n_vec++; if (out_TVALID !== 1'b0) begin n_fail++; $display("FAIL rst_out_tvalid got=%b exp=0", out_TVALID); end
    n_vec++; if (in_TREADY !== '0) begin n_fail++; $display("FAIL rst_in_tready got=%b exp=0000", in_TREADY); end
    n_vec++; if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++; $display("FAIL rst_grant got=%b/%0d exp=0/0", grant_valid, grant_id);
    end
    n_vec++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL rst_pkt_done got=%b exp=0", pkt_done); end
    n_vec++; if ({out_TDATA, out_TKEEP, out_TLAST} !== 37'd0) begin
      n_fail++; $display("FAIL rst_out_data got=%h/%h/%b exp=0", out_TDATA, out_TKEEP, out_TLAST);
    end
    n_vec++; if (dut.rr_ptr_q !== 2'd0) begin n_fail++; $display("FAIL rst_rr_ptr got=%0d exp=0", dut.rr_ptr_q); end
  endtask

  task automatic test_single();
    int t0;
    bit ok;
    do_reset();
    push_src(2, 3, 32'hA0);
    push_exp(2, 3, 32'hA0);
    @(posedge clk); #2;
    t0 = cyc;
    wait_drain(20, ok);
    n_vec++; if (!ok) begin n_fail++; $display("FAIL single_drain got=%0d left exp=0", exp_q.size()); end
    n_vec++;
    if (hs_edges.size() != 3) begin
      n_fail++; $display("FAIL single_beats got=%0d exp=3", hs_edges.size());
    end else begin
      if (hs_edges[0] != t0 + 2) begin
        n_fail++; $display("FAIL single_first_lat got=%0d exp=%0d", hs_edges[0] - t0, 2);
      end
      n_vec++;
      if (hs_edges[2] != t0 + 4) begin
        n_fail++; $display("FAIL single_last_edge got=%0d exp=%0d", hs_edges[2] - t0, 4);
      end
    end
    @(negedge clk);
    n_vec++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL single_pkt_done got=%b exp=1", pkt_done); end
    n_vec++; if (dut.rr_ptr_q !== 2'd3) begin n_fail++; $display("FAIL single_rr_ptr got=%0d exp=3", dut.rr_ptr_q); end
  endtask

  task automatic test_all_ports();
    bit ok;
    do_reset();
    push_src(0, 2, 32'h100); push_src(0, 2, 32'h110);
    push_src(1, 2, 32'h200); push_src(1, 2, 32'h210);
    push_src(2, 2, 32'h300);
    push_src(3, 2, 32'h400);
    push_exp(0, 2, 32'h100); push_exp(1, 2, 32'h200); push_exp(2, 2, 32'h300);
    push_exp(3, 2, 32'h400); push_exp(0, 2, 32'h110); push_exp(1, 2, 32'h210);
    wait_drain(40, ok);
    n_vec++; if (!ok) begin n_fail++; $display("FAIL rr_drain got=%0d left exp=0", exp_q.size()); end
    n_vec++;
    if (hs_edges.size() != 12) begin
      n_fail++; $display("FAIL rr_beats got=%0d exp=12", hs_edges.size());
    end else if (hs_edges[11] - hs_edges[0] != 16) begin
      n_fail++; $display("FAIL rr_span got=%0d exp=16", hs_edges[11] - hs_edges[0]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    do_reset();
    push_src(1, 4, 32'h600);
    push_exp(1, 4, 32'h600);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (grant_valid) begin ok = 1'b1; break; end
    end
    n_vec++; if (!ok) begin n_fail++; $display("FAIL bp_grant got=0 exp=1"); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      out_TREADY = pat[i];
    end
    @(posedge clk); #1;
    out_TREADY = 1'b1;
    wait_drain(20, ok);
    n_vec++; if (!ok) begin n_fail++; $display("FAIL bp_drain got=%0d left exp=0", exp_q.size()); end
    n_vec++; if (hs_edges.size() != 4) begin n_fail++; $display("FAIL bp_beats got=%0d exp=4", hs_edges.size()); end
  endtask

  task automatic test_port_en();
    bit ok;
    do_reset();
    port_en = 4'b1011;
    for (int p = 0; p < NP; p++) push_src(p, 2, 32'h800 + 32'(p * 16));
    push_exp(0, 2, 32'h800); push_exp(1, 2, 32'h810); push_exp(3, 2, 32'h830);
    wait_drain(30, ok);
    n_vec++; if (!ok) begin n_fail++; $display("FAIL en_drain got=%0d left exp=0", exp_q.size()); end
    repeat (6) @(negedge clk);
    n_vec++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL en_port2_grant got=%b exp=0", grant_valid); end

    do_reset();
    push_src(0, 4, 32'h900); push_src(0, 2, 32'h910);
    push_src(1, 2, 32'h920);
    push_exp(0, 4, 32'h900); push_exp(1, 2, 32'h920);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (hs_edges.size() >= 2) begin ok = 1'b1; break; end
    end
    n_vec++; if (!ok) begin n_fail++; $display("FAIL en_mid_start got=%0d beats exp=2", hs_edges.size()); end
    port_en[0] = 1'b0;
    wait_drain(30, ok);
    n_vec++; if (!ok) begin n_fail++; $display("FAIL en_mid_drain got=%0d left exp=0", exp_q.size()); end
    repeat (6) @(negedge clk);
    n_vec++; if (hs_edges.size() != 6) begin n_fail++; $display("FAIL en_mid_beats got=%0d exp=6", hs_edges.size()); end
    n_vec++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL en_port0_regrant got=%b exp=0", grant_valid); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    do_reset();
    push_src(3, 4, 32'hB00);
    push_exp(3, 4, 32'hB00);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (hs_edges.size() >= 1) begin ok = 1'b1; break; end
    end
    n_vec++; if (!ok) begin n_fail++; $display("FAIL mid_rst_start got=0 beats exp=1"); end
    #2 rst_low = 1'b0;
    #1;
    n_vec++; if (out_TVALID !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_tvalid got=%b exp=0", out_TVALID); end
    n_vec++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_grant got=%b exp=0", grant_valid); end
    n_vec++; if (in_TREADY !== '0) begin n_fail++; $display("FAIL mid_rst_in_tready got=%b exp=0000", in_TREADY); end
    flush_all();
    push_src(3, 2, 32'hC30); push_src(2, 2, 32'hC20);
    push_exp(2, 2, 32'hC20); push_exp(3, 2, 32'hC30);
    repeat (2) @(posedge clk);
    #2 rst_low = 1'b1;
    wait_drain(30, ok);
    n_vec++; if (!ok) begin n_fail++; $display("FAIL mid_rst_drain got=%0d left exp=0", exp_q.size()); end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_single();
    test_all_ports();
    test_backpressure();
    test_port_en();
    test_reset_mid_packet();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
